// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: opcode encodings, the buffered
// entry layout and the rule for which opcodes produce a meaningful carry.
package alu_result_stage_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INCA = 3'b010;
    localparam logic [2:0] OP_DECB = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOTB = 3'b111;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       n;
    } entry_t;

    // Only the arithmetic opcodes drive bit 4 of the result; logical ops leave it meaningless.
    function automatic logic sel_has_carry(input logic [2:0] sel);
        logic arith;
        arith = 1'b0;
        unique case (sel)
            OP_ADD, OP_SUB, OP_INCA, OP_DECB: arith = 1'b1;
            OP_AND, OP_OR, OP_XOR, OP_NOTB:   arith = 1'b0;
            default:                          arith = 1'b0;
        endcase
        return arith;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational condition-flag generator: carry/borrow, zero and negative
// derived from one ALU opcode/result pair.
module alu_flag_gen
    import alu_result_stage_pkg::*;
(
    input  logic [2:0] sel_i,
    input  logic [4:0] y_i,
    output logic       c_o,
    output logic       z_o,
    output logic       n_o
);

    assign c_o = sel_has_carry(sel_i) & y_i[4];
    assign z_o = (y_i[3:0] == 4'd0);
    assign n_o = y_i[3];

endmodule

// File: rtl/alu_result_stage.sv
// Registered downstream stage of the 4-bit ALU: flags each result, queues it in
// a DEPTH-entry FIFO behind valid/ready, and counts carry/borrow events.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int CNT_W = 8,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [4:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sel,
    output logic [3:0]       out_res,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] c_cnt,
    output logic [LVL_W-1:0] level
);

    entry_t             mem_q [DEPTH];
    entry_t             in_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   c_cnt_q, c_cnt_d;
    logic               flag_c, flag_z, flag_n;
    logic               push, pop;

    alu_flag_gen u_flag_gen (
        .sel_i (in_sel),
        .y_i   (in_y),
        .c_o   (flag_c),
        .z_o   (flag_z),
        .n_o   (flag_n)
    );

    assign in_entry  = '{sel: in_sel, res: in_y[3:0], c: flag_c, z: flag_z, n: flag_n};
    assign in_ready  = (level_q < LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Gating with out_valid gives clean zeros while empty, so storage needs no reset.
    assign head    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_sel = head.sel;
    assign out_res = head.res;
    assign out_c   = head.c;
    assign out_z   = head.z;
    assign out_n   = head.n;
    assign c_cnt   = c_cnt_q;
    assign level   = level_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        c_cnt_d  = c_cnt_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (cnt_clr)
            c_cnt_d = '0;
        else if (push && flag_c && (c_cnt_q != '1))
            c_cnt_d = c_cnt_q + 1'b1;
    end

    // NOTE: the entry array is deliberately left out of reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            c_cnt_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            c_cnt_q  <= c_cnt_d;
        end
    end

endmodule
